// File: rtl/mynet_layer_pkg.sv
// Shared types and fixed-point helpers for the time-multiplexed layer.
// Saturating helpers work on a 64-bit container; callers pass the real width.
package mynet_layer_pkg;

   typedef enum logic [1:0] {
      S_LOAD,
      S_MAC,
      S_BIAS,
      S_EMIT
   } state_e;

   typedef enum logic {
      ACT_RELU,
      ACT_NONE
   } act_e;

   localparam int MAXW = 64;

   function automatic int frac_bits(input int dw, input int wi);
      return dw - wi;
   endfunction

   // a, b are sign-extended values of width w; result clamps to w bits
   function automatic logic signed [MAXW-1:0] sat_add(
      input logic signed [MAXW-1:0] a,
      input logic signed [MAXW-1:0] b,
      input int                     w
   );
      logic signed [MAXW:0] s;
      logic signed [MAXW:0] mx;
      logic signed [MAXW:0] mn;
      s  = $signed({a[MAXW-1], a}) + $signed({b[MAXW-1], b});
      mx = $signed(((MAXW+1)'(1) << (w - 1)) - (MAXW+1)'(1));
      mn = -mx - $signed((MAXW+1)'(1));
      if (s > mx) return mx[MAXW-1:0];
      if (s < mn) return mn[MAXW-1:0];
      return s[MAXW-1:0];
   endfunction

   function automatic logic signed [MAXW-1:0] sat_trunc(
      input logic signed [MAXW-1:0] a,
      input int                     sh,
      input int                     w
   );
      logic signed [MAXW-1:0] t;
      logic signed [MAXW-1:0] mx;
      logic signed [MAXW-1:0] mn;
      t  = a >>> sh;
      mx = $signed((MAXW'(1) << (w - 1)) - MAXW'(1));
      mn = -mx - $signed(MAXW'(1));
      if (t > mx) return mx;
      if (t < mn) return mn;
      return t;
   endfunction

endpackage

// File: rtl/layer_tm_lane.sv
// One MAC lane: signed product, saturating accumulate, bias add,
// then shift/clamp to the data width and optional ReLU.
module layer_tm_lane
   import mynet_layer_pkg::*;
#(
   parameter int   DW  = 16,
   parameter int   WI  = 4,
   parameter act_e ACT = ACT_RELU
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          en_i,
   input  logic          bias_en_i,
   input  logic [DW-1:0] x_i,
   input  logic [DW-1:0] w_i,
   input  logic [DW-1:0] b_i,
   output logic [DW-1:0] y_o
);

   localparam int FRAC = frac_bits(DW, WI);
   localparam int AW2  = 2 * DW;

   logic signed [AW2-1:0]  acc_q;
   logic signed [AW2-1:0]  acc_d;
   logic signed [AW2-1:0]  prod;
   logic signed [AW2-1:0]  bext;
   logic signed [AW2-1:0]  bsh;
   logic signed [MAXW-1:0] t_full;

   assign prod = $signed(x_i) * $signed(w_i);
   assign bext = {{DW{b_i[DW-1]}}, b_i};
   assign bsh  = bext <<< FRAC;

   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = AW2'(sat_add(MAXW'(acc_q), MAXW'(prod), AW2));
      end else if (bias_en_i) begin
         acc_d = AW2'(sat_add(MAXW'(acc_q), MAXW'(bsh), AW2));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) acc_q <= '0;
      else      acc_q <= acc_d;
   end

   assign t_full = sat_trunc(MAXW'(acc_q), FRAC, DW);
   assign y_o    = (ACT == ACT_RELU && t_full[MAXW-1]) ? '0
                                                       : t_full[DW-1:0];

endmodule

// File: rtl/layer_tm.sv
// Time-multiplexed fully-connected layer: LANES MAC lanes sweep NN neurons
// in passes over one buffered input vector, streaming one neuron per beat.
module layer_tm
   import mynet_layer_pkg::*;
#(
   parameter int NN               = 10,
   parameter int NUM_WEIGHT       = 784,
   parameter int DATA_WIDTH       = 16,
   parameter int WEIGHT_INT_WIDTH = 4,
   parameter int LANES            = 2,
   parameter int LAYER_NUM        = 1,
   parameter     ACT_TYPE         = "relu"
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  weightValid,
   input  logic                  biasValid,
   input  logic [31:0]           weightValue,
   input  logic [31:0]           biasValue,
   input  logic [31:0]           config_layer_num,
   input  logic [31:0]           config_neuron_num,
   input  logic                  x_valid,
   output logic                  x_ready,
   input  logic [DATA_WIDTH-1:0] x_in,
   output logic                  o_valid,
   input  logic                  o_ready,
   output logic [$clog2(NN)-1:0] o_idx,
   output logic [DATA_WIDTH-1:0] x_out,
   output logic                  o_last,
   output logic                  busy,
   output logic                  wr_err
);

   localparam int   DW     = DATA_WIDTH;
   localparam int   PASSES = (NN + LANES - 1) / LANES;
   localparam int   IDXW   = $clog2(NN);
   localparam int   WPW    = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
   localparam int   KW     = $clog2(NUM_WEIGHT + 1);
   localparam int   PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam int   LW     = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int   DEPTH  = PASSES * NUM_WEIGHT;
   localparam int   AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam act_e ACT    = (ACT_TYPE == "none") ? ACT_NONE : ACT_RELU;

   state_e          state_q, state_d;
   logic [WPW-1:0]  k_q, k_d;
   logic [KW-1:0]   j_q, j_d;
   logic [PW-1:0]   p_q, p_d;
   logic [LW-1:0]   e_q, e_d;
   logic [WPW-1:0]  wp_q, wp_d;
   logic [31:0]     wn_q, wn_d;
   logic            wr_err_q, wr_err_d;

   logic [DW-1:0]   xbuf [NUM_WEIGHT];
   logic [DW-1:0]   wram [LANES][DEPTH];
   logic [DW-1:0]   bram [NN];
   logic [DW-1:0]   xr_q;
   logic [DW-1:0]   wr_q   [LANES];
   logic [DW-1:0]   lane_b [LANES];
   logic [DW-1:0]   lane_y [LANES];

   logic            layer_hit;
   logic            nr_ok;
   logic            wr_ok;
   logic [LW-1:0]   w_lane;
   logic [PW-1:0]   w_row;
   logic [WPW-1:0]  w_ptr;
   logic [AW-1:0]   w_addr;
   logic [AW-1:0]   r_addr;
   logic [WPW-1:0]  rd_j;
   logic            rd_en;
   logic [31:0]     cur_n;
   logic            lane_end;
   logic            mac_clr;
   logic            mac_en;
   logic            bias_en;

   // ---------------- write path ----------------
   assign layer_hit = config_layer_num == 32'(LAYER_NUM);
   assign nr_ok     = config_neuron_num < 32'(NN);
   assign wr_ok     = layer_hit && nr_ok && state_q == S_LOAD;
   assign w_lane    = LW'(config_neuron_num % 32'(LANES));
   assign w_row     = PW'(config_neuron_num / 32'(LANES));
   // a new target neuron restarts its weight row at index 0
   assign w_ptr     = (config_neuron_num != wn_q) ? '0 : wp_q;
   assign w_addr    = AW'(32'(w_row) * 32'(NUM_WEIGHT) + 32'(w_ptr));

   always_comb begin
      wp_d     = wp_q;
      wn_d     = wn_q;
      wr_err_d = layer_hit && (weightValid || biasValid) && !wr_ok;
      if (weightValid && wr_ok) begin
         wn_d = config_neuron_num;
         wp_d = (w_ptr == WPW'(NUM_WEIGHT - 1)) ? '0 : w_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (weightValid && wr_ok) wram[w_lane][w_addr] <= weightValue[DW-1:0];
      if (biasValid && wr_ok)   bram[IDXW'(config_neuron_num)] <= biasValue[DW-1:0];
   end

   // ---------------- input buffer and operand reads ----------------
   always_ff @(posedge clk) begin
      if (state_q == S_LOAD && x_valid) xbuf[k_q] <= x_in;
   end

   assign rd_j   = WPW'(j_q);
   assign rd_en  = state_q == S_MAC && j_q != KW'(NUM_WEIGHT);
   assign r_addr = AW'(32'(p_q) * 32'(NUM_WEIGHT) + 32'(j_q));

   always_ff @(posedge clk) begin
      if (rd_en) begin
         xr_q <= xbuf[rd_j];
         for (int l = 0; l < LANES; l++) wr_q[l] <= wram[l][r_addr];
      end
   end

   // ---------------- control FSM ----------------
   assign cur_n    = 32'(p_q) * 32'(LANES) + 32'(e_q);
   assign lane_end = (e_q == LW'(LANES - 1)) || (cur_n + 32'd1 >= 32'(NN));

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      j_d     = j_q;
      p_d     = p_q;
      e_d     = e_q;
      unique case (state_q)
         S_LOAD: begin
            if (x_valid) begin
               if (k_q == WPW'(NUM_WEIGHT - 1)) begin
                  k_d     = '0;
                  j_d     = '0;
                  p_d     = '0;
                  state_d = S_MAC;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         S_MAC: begin
            // j=0 clears, j=1..NUM_WEIGHT consume the registered reads
            if (j_q == KW'(NUM_WEIGHT)) begin
               j_d     = '0;
               state_d = S_BIAS;
            end else begin
               j_d = j_q + 1'b1;
            end
         end
         S_BIAS: begin
            e_d     = '0;
            state_d = S_EMIT;
         end
         S_EMIT: begin
            if (o_ready) begin
               if (!lane_end) begin
                  e_d = e_q + 1'b1;
               end else if (p_q == PW'(PASSES - 1)) begin
                  k_d     = '0;
                  state_d = S_LOAD;
               end else begin
                  p_d     = p_q + 1'b1;
                  j_d     = '0;
                  state_d = S_MAC;
               end
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_LOAD;
         k_q      <= '0;
         j_q      <= '0;
         p_q      <= '0;
         e_q      <= '0;
         wp_q     <= '0;
         wn_q     <= '0;
         wr_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         j_q      <= j_d;
         p_q      <= p_d;
         e_q      <= e_d;
         wp_q     <= wp_d;
         wn_q     <= wn_d;
         wr_err_q <= wr_err_d;
      end
   end

   // ---------------- lanes ----------------
   assign mac_clr = state_q == S_MAC && j_q == '0;
   assign mac_en  = state_q == S_MAC && j_q != '0;
   assign bias_en = state_q == S_BIAS;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [31:0] n;
      assign n         = 32'(p_q) * 32'(LANES) + 32'(l);
      assign lane_b[l] = (n < 32'(NN)) ? bram[IDXW'(n)] : '0;

      layer_tm_lane #(
         .DW  (DW),
         .WI  (WEIGHT_INT_WIDTH),
         .ACT (ACT)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .clr_i     (mac_clr),
         .en_i      (mac_en),
         .bias_en_i (bias_en),
         .x_i       (xr_q),
         .w_i       (wr_q[l]),
         .b_i       (lane_b[l]),
         .y_o       (lane_y[l])
      );
   end

   // ---------------- outputs ----------------
   assign x_ready = state_q == S_LOAD;
   assign busy    = state_q != S_LOAD;
   assign o_valid = state_q == S_EMIT;
   assign o_idx   = o_valid ? IDXW'(cur_n) : '0;
   assign x_out   = o_valid ? lane_y[e_q] : '0;
   assign o_last  = o_valid && cur_n == 32'(NN - 1);
   assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_layer_tm.sv
// Directed bench for layer_tm: two instances (relu / none) driven in lockstep,
// results checked against a small fixed-point model of the neuron.
module tb_layer_tm;

   localparam int NN  = 3;
   localparam int NW  = 4;
   localparam int LN  = 2;
   localparam int DW  = 16;
   localparam int LAY = 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          weightValid = 1'b0;
   logic          biasValid = 1'b0;
   logic [31:0]   weightValue = '0;
   logic [31:0]   biasValue = '0;
   logic [31:0]   config_layer_num = '0;
   logic [31:0]   config_neuron_num = '0;
   logic          x_valid = 1'b0;
   logic [DW-1:0] x_in = '0;
   logic          o_ready = 1'b1;

   logic          a_x_ready, a_o_valid, a_o_last, a_busy, a_wr_err;
   logic [1:0]    a_o_idx;
   logic [DW-1:0] a_x_out;
   logic          b_x_ready, b_o_valid, b_o_last, b_busy, b_wr_err;
   logic [1:0]    b_o_idx;
   logic [DW-1:0] b_x_out;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] wm [NN][NW];
   logic [15:0] bm [NN];
   logic [15:0] xv [NW];

   always #5 clk = ~clk;

   layer_tm #(
      .NN(NN), .NUM_WEIGHT(NW), .DATA_WIDTH(DW), .WEIGHT_INT_WIDTH(4),
      .LANES(LN), .LAYER_NUM(LAY), .ACT_TYPE("relu")
   ) u_relu (
      .clk(clk), .rst(rst), .weightValid(weightValid), .biasValid(biasValid),
      .weightValue(weightValue), .biasValue(biasValue),
      .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
      .x_valid(x_valid), .x_ready(a_x_ready), .x_in(x_in),
      .o_valid(a_o_valid), .o_ready(o_ready), .o_idx(a_o_idx), .x_out(a_x_out),
      .o_last(a_o_last), .busy(a_busy), .wr_err(a_wr_err)
   );

   layer_tm #(
      .NN(NN), .NUM_WEIGHT(NW), .DATA_WIDTH(DW), .WEIGHT_INT_WIDTH(4),
      .LANES(LN), .LAYER_NUM(LAY), .ACT_TYPE("none")
   ) u_none (
      .clk(clk), .rst(rst), .weightValid(weightValid), .biasValid(biasValid),
      .weightValue(weightValue), .biasValue(biasValue),
      .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
      .x_valid(x_valid), .x_ready(b_x_ready), .x_in(x_in),
      .o_valid(b_o_valid), .o_ready(o_ready), .o_idx(b_o_idx), .x_out(b_x_out),
      .o_last(b_o_last), .busy(b_busy), .wr_err(b_wr_err)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] model(input int n, input bit relu);
      longint acc = 0;
      longint y;
      for (int j = 0; j < NW; j++) begin
         acc += longint'($signed(xv[j])) * longint'($signed(wm[n][j]));
         if (acc > 64'sd2147483647) acc = 64'sd2147483647;
         if (acc < -64'sd2147483648) acc = -64'sd2147483648;
      end
      acc += longint'($signed(bm[n])) * 4096;
      if (acc > 64'sd2147483647) acc = 64'sd2147483647;
      if (acc < -64'sd2147483648) acc = -64'sd2147483648;
      y = acc >>> 12;
      if (y > 32767) y = 32767;
      if (y < -32768) y = -32768;
      if (relu && y < 0) y = 0;
      return 16'(y);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_neuron(input int n);
      for (int j = 0; j < NW; j++) begin
         weightValid       = 1'b1;
         biasValid         = (j == 0);
         weightValue       = {16'hA5A5, wm[n][j]};
         biasValue         = {16'h5A5A, bm[n]};
         config_layer_num  = LAY;
         config_neuron_num = n;
         tick();
      end
      weightValid = 1'b0;
      biasValid   = 1'b0;
   endtask

   task automatic load_all();
      for (int n = 0; n < NN; n++) wr_neuron(n);
   endtask

   task automatic send(input int gapmax);
      for (int k = 0; k < NW; k++) begin
         x_valid = 1'b1;
         x_in    = xv[k];
         tick();
         x_valid = 1'b0;
         if (k < NW - 1 && gapmax > 0) repeat ($urandom_range(gapmax)) tick();
      end
   endtask

   task automatic recv(input string tag, input int stall_idx, input bit chk_lat);
      int            cyc;
      logic [1:0]    s_idx;
      logic [DW-1:0] s_out;
      for (int b = 0; b < NN; b++) begin
         cyc = 0;
         while (!a_o_valid && cyc < 200) begin
            tick();
            cyc++;
         end
         // edges after the accepting edge of the last sample
         if (b == 0 && chk_lat) chk({tag, "_latency"}, cyc, NW + 2);
         chk({tag, "_valid"}, a_o_valid, 1);
         if (!a_o_valid) return;
         chk({tag, "_idx"}, a_o_idx, b);
         chk({tag, "_relu"}, a_x_out, model(b, 1));
         chk({tag, "_none"}, b_x_out, model(b, 0));
         chk({tag, "_last"}, a_o_last, (b == NN - 1));
         if (b == stall_idx) begin
            s_idx   = a_o_idx;
            s_out   = a_x_out;
            o_ready = 1'b0;
            repeat (10) tick();
            chk({tag, "_hold_valid"}, a_o_valid, 1);
            chk({tag, "_hold_idx"}, a_o_idx, s_idx);
            chk({tag, "_hold_out"}, a_x_out, s_out);
            o_ready = 1'b1;
         end
         tick();
      end
      chk({tag, "_no_phantom"}, a_o_valid, 0);
      chk({tag, "_x_ready"}, a_x_ready, 1);
   endtask

   initial begin
      int seen;
      int t;

      #2 rst = 1'b0;
      #1;
      chk("rst_x_ready", a_x_ready, 1);
      chk("rst_o_valid", a_o_valid, 0);
      chk("rst_o_idx", a_o_idx, 0);
      chk("rst_x_out", a_x_out, 0);
      chk("rst_o_last", a_o_last, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_wr_err", a_wr_err, 0);
      tick();
      rst = 1'b1;
      tick();

      // 1.0 weights, 0.5 inputs: 4 * 0.5 = 2.0 -> 0x2000
      for (int n = 0; n < NN; n++) begin
         bm[n] = 16'h0000;
         for (int j = 0; j < NW; j++) wm[n][j] = 16'h1000;
      end
      for (int j = 0; j < NW; j++) xv[j] = 16'h0800;
      load_all();
      send(0);
      recv("basic", -1, 1);
      chk("basic_const", {16'h0, model(2, 1)}, 32'h2000);

      // mixed-sign weights, input gaps, stall on beat idx 1
      for (int n = 0; n < NN; n++) begin
         t = $urandom_range(0, 16383);
         bm[n] = 16'(t - 8192);
         for (int j = 0; j < NW; j++) begin
            t = $urandom_range(0, 8191);
            wm[n][j] = 16'(t - 4096);
         end
      end
      for (int j = 0; j < NW; j++) xv[j] = 16'($urandom);
      load_all();
      send(3);
      recv("bp", 1, 0);

      // write while computing is dropped and flagged
      send(0);
      chk("busy_mac", a_busy, 1);
      weightValid       = 1'b1;
      weightValue       = 32'h0000_1234;
      config_layer_num  = LAY;
      config_neuron_num = 0;
      tick();
      weightValid = 1'b0;
      chk("wr_err_mac", a_wr_err, 1);
      tick();
      chk("wr_err_pulse", a_wr_err, 0);
      recv("after_drop", -1, 0);

      // out-of-range neuron in S_LOAD: flagged
      biasValid         = 1'b1;
      config_neuron_num = NN;
      tick();
      biasValid = 1'b0;
      chk("wr_err_range", a_wr_err, 1);
      tick();

      // other layer: silently ignored
      weightValid       = 1'b1;
      biasValid         = 1'b1;
      weightValue       = '0;
      biasValue         = '0;
      config_layer_num  = LAY + 1;
      config_neuron_num = 0;
      tick();
      weightValid = 1'b0;
      biasValid   = 1'b0;
      chk("wr_err_layer", a_wr_err, 0);
      tick();
      send(1);
      recv("after_layer", -1, 0);

      // positive saturation
      for (int n = 0; n < NN; n++) begin
         bm[n] = 16'h7FFF;
         for (int j = 0; j < NW; j++) wm[n][j] = 16'h7FFF;
      end
      for (int j = 0; j < NW; j++) xv[j] = 16'h7FFF;
      load_all();
      send(0);
      recv("sat_pos", -1, 0);

      // negative saturation: none -> 0x8000, relu -> 0
      for (int n = 0; n < NN; n++) begin
         bm[n] = 16'h0000;
         for (int j = 0; j < NW; j++) wm[n][j] = 16'h8000;
      end
      load_all();
      send(0);
      recv("sat_neg", -1, 0);
      chk("sat_neg_const", {16'h0, model(0, 0)}, 32'h8000);

      // reset in the middle of a pass
      send(0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("mid_rst_x_ready", a_x_ready, 1);
      chk("mid_rst_o_valid", a_o_valid, 0);
      chk("mid_rst_busy", a_busy, 0);
      chk("mid_rst_x_out", a_x_out, 0);
      tick();
      rst  = 1'b1;
      seen = 0;
      repeat (NW + 10) begin
         tick();
         if (a_o_valid) seen++;
      end
      chk("no_beat_after_rst", seen, 0);
      for (int j = 0; j < NW; j++) xv[j] = 16'($urandom);
      send(2);
      recv("post_rst", -1, 0);

      // random vectors with input gaps
      for (int r = 0; r < 3; r++) begin
         for (int n = 0; n < NN; n++) begin
            t = $urandom_range(0, 16383);
            bm[n] = 16'(t - 8192);
            for (int j = 0; j < NW; j++) begin
               t = $urandom_range(0, 8191);
               wm[n][j] = 16'(t - 4096);
            end
         end
         for (int j = 0; j < NW; j++) xv[j] = 16'($urandom);
         load_all();
         send(3);
         recv("rand", -1, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
